// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the sort sequencer slice.
//   - FSM state encodings (2-bit; the spare encoding recovers to LOAD)
//   - sort-order constants
//   - idx_w(): counter width helper for a given batch depth
package sort_sequencer_pkg;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SORT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

    // Width of wr_idx/rd_idx/j/pass. Depth is at least 2, so this is at least 1.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/juntarComparadores.sv
// Unsigned magnitude comparator built as a bit-serial ripple chain.
// Ports:
//   a, b : Size-bit unsigned operands
//   g    : a > b
//   l    : a < b
// The chain runs LSB to MSB so a differing higher bit overrides whatever
// the lower bits decided.
module juntarComparadores #(
    parameter int Size = 8
) (
    input  logic [Size-1:0] a,
    input  logic [Size-1:0] b,
    output logic            g,
    output logic            l
);

    logic [Size:0] g_c;
    logic [Size:0] l_c;

    assign g_c[0] = 1'b0;
    assign l_c[0] = 1'b0;

    for (genvar i = 0; i < Size; i++) begin : g_bit
        assign g_c[i+1] = (a[i] & ~b[i]) | (~(a[i] ^ b[i]) & g_c[i]);
        assign l_c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & l_c[i]);
    end

    assign g = g_c[Size];
    assign l = l_c[Size];

endmodule

// File: rtl/sort_sequencer_cmp_swap.sv
// Compare/swap decision for one adjacent pair of the sort buffer.
// Ports:
//   a, b   : mem[j], mem[j+1]
//   desc_q : latched sort order (ASC/DESC)
//   swap   : exchange a and b this cycle
// Equal words never swap, which keeps the sort stable.
module cmp_swap
    import sort_sequencer_pkg::*;
#(
    parameter int Size = 8
) (
    input  logic [Size-1:0] a,
    input  logic [Size-1:0] b,
    input  logic            desc_q,
    output logic            swap
);

    logic g;
    logic l;

    juntarComparadores #(Size) u_cmp (
        .a (a),
        .b (b),
        .g (g),
        .l (l)
    );

    assign swap = (desc_q == DESC) ? l : g;

endmodule

// File: rtl/sort_sequencer.sv
// Sequential bubble sorter around one shared comparator.
// Loads Depth words, sorts them in place with a fixed (Depth-1)^2-cycle
// schedule (one compare/swap per cycle), then streams them out.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : load handshake, in_data word, desc order
//                         (desc sampled with the first word of a batch)
//   out_valid/out_ready : drain handshake, out_data sorted word
//   busy                : high while sorting or draining
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int Size  = 8,
    parameter int Depth = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Size-1:0] in_data,
    input  logic            desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Size-1:0] out_data,
    output logic            busy
);

    localparam int IW = idx_w(Depth);
    localparam logic [IW-1:0] IDX_LAST = IW'(Depth - 1);
    localparam logic [IW-1:0] IDX_PAIR = IW'(Depth - 2);

    logic [1:0]                  state;
    logic [1:0]                  state_nxt;
    logic [IW-1:0]               wr_idx;
    logic [IW-1:0]               rd_idx;
    logic [IW-1:0]               j;
    logic [IW-1:0]               j_nx;
    logic [IW-1:0]               pass;
    logic                        desc_q;
    logic [Depth-1:0][Size-1:0]  mem;
    logic [Size-1:0]             a;
    logic [Size-1:0]             b;
    logic                        swap;

    // j never exceeds Depth-2, so j+1 always fits in IW bits.
    assign j_nx = j + 1'b1;
    assign a    = mem[j];
    assign b    = mem[j_nx];

    cmp_swap #(.Size(Size)) u_cmp_swap (
        .a      (a),
        .b      (b),
        .desc_q (desc_q),
        .swap   (swap)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (in_valid && wr_idx == IDX_LAST)             state_nxt = S_SORT;
            S_SORT:  if (pass == IDX_PAIR && j == IDX_PAIR)          state_nxt = S_DRAIN;
            S_DRAIN: if (out_ready && rd_idx == IDX_LAST)            state_nxt = S_LOAD;
            default:                                                 state_nxt = S_LOAD;
        endcase
    end

    // Outputs: out_data comes straight from registered storage.
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_DRAIN);
        busy      = (state == S_SORT) || (state == S_DRAIN);
        out_data  = '0;
        if (state == S_DRAIN) out_data = mem[rd_idx];
    end

    // Counters and order latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            j      <= '0;
            pass   <= '0;
            desc_q <= ASC;
        end else begin
            case (state)
                S_LOAD: if (in_valid) begin
                    if (wr_idx == '0) desc_q <= desc;
                    if (wr_idx == IDX_LAST) begin
                        wr_idx <= '0;
                        pass   <= '0;
                        j      <= '0;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end
                S_SORT: begin
                    if (j == IDX_PAIR) begin
                        j <= '0;
                        if (pass == IDX_PAIR) begin
                            pass   <= '0;
                            rd_idx <= '0;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        j <= j_nx;
                    end
                end
                S_DRAIN: if (out_ready) begin
                    rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage: no reset, contents are don't-care until loaded.
    // A swap writes both halves of the pair in the same cycle.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem[wr_idx] <= in_data;
        end else if (state == S_SORT && swap) begin
            mem[j]    <= b;
            mem[j_nx] <= a;
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
module tb_sort_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       desc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    sort_sequencer #(.Size(8), .Depth(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .desc      (desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference order: simple selection into a fresh array.
    task automatic push_sorted(input logic [7:0] w[4], input logic d);
        logic [7:0] s[4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) s[i] = w[i];
        for (int i = 0; i < 4; i++)
            for (int k = i + 1; k < 4; k++)
                if (d ? (s[k] > s[i]) : (s[k] < s[i])) begin
                    t = s[i]; s[i] = s[k]; s[k] = t;
                end
        for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic load_batch(input logic [7:0] w[4], input logic d, input int gap);
        int guard;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            desc     = d;
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("load_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        push_sorted(w, d);
    endtask

    // Called on the falling edge right after the last accept.
    task automatic wait_sort(input string tag);
        int cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (in_ready || !busy) chk({tag, "_sort_flags"}, {in_ready, busy}, 2'b01);
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_sort_cycles"}, cnt, 9);
    endtask

    task automatic drain(input string tag, input bit stall);
        int n = 0;
        int guard = 0;
        int st = 0;
        while (n < 4 && guard < 100) begin
            guard++;
            if (stall && n == 1 && st < 3) begin
                out_ready = 1'b0;
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_data"}, out_data, exp_q.size() ? exp_q[0] : 0);
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk({tag, "_out"}, out_data, exp_q.size() ? exp_q.pop_front() : 0);
                    n++;
                end
            end
            @(negedge clk);
        end
        if (n < 4) chk({tag, "_drain_timeout"}, n, 4);
        chk({tag, "_ready_after"}, in_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_valid_after"}, out_valid, 0);
    endtask

    task automatic run(input string tag, input logic [7:0] w[4], input logic d,
                       input int gap, input bit stall);
        load_batch(w, d, gap);
        wait_sort(tag);
        drain(tag, stall);
    endtask

    initial begin
        logic [7:0] w[4];
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; desc = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);

        w = '{8'h35, 8'h07, 8'hFF, 8'h80}; run("asc", w, 1'b0, 0, 1'b0);
        w = '{8'h05, 8'h00, 8'h05, 8'hFF}; run("desc_dup", w, 1'b1, 0, 1'b0);
        w = '{8'h05, 8'h05, 8'h03, 8'h05}; run("asc_dup", w, 1'b0, 0, 1'b0);
        w = '{8'h10, 8'h30, 8'h20, 8'h40}; run("bp", w, 1'b0, 0, 1'b1);
        w = '{8'h09, 8'h01, 8'h08, 8'h02}; run("gaps", w, 1'b0, 2, 1'b0);

        // Producer holds a word through SORT/DRAIN; it must open the next batch.
        w = '{8'h04, 8'h03, 8'h02, 8'h01};
        load_batch(w, 1'b0, 0);
        in_valid = 1'b1; in_data = 8'h66; desc = 1'b0;
        wait_sort("hold");
        drain("hold", 1'b0);
        w = '{8'h66, 8'h11, 8'h99, 8'h22}; run("hold_next", w, 1'b0, 0, 1'b0);

        w = '{8'h01, 8'h02, 8'h03, 8'h04}; run("sorted", w, 1'b0, 0, 1'b0);
        w = '{8'h04, 8'h03, 8'h02, 8'h01}; run("reverse", w, 1'b0, 0, 1'b0);

        // Reset during SORT cycle 5 discards the batch.
        w = '{8'hAA, 8'h55, 8'hCC, 8'h33};
        load_batch(w, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_busy", busy, 0);
        w = '{8'h04, 8'h03, 8'h02, 8'h01}; run("post_rst", w, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Sequential sorter built around one shared magnitude comparator (the existing juntarComparadores chain, g/l outputs).
- Loads Depth words over a valid/ready input port and sorts them in place with a fixed-schedule bubble sort, one compare/swap per cycle.
- Streams the sorted words out over a valid/ready output port.
- Sits between a word producer and a consumer; it is the controller that sequences the comparator datapath.

Parameters:
- Size, 8, word width in bits (>=1)
- Depth, 4, number of words per sort batch (>=2)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  producer offers in_data
- in_ready  output  1  block accepts a word this cycle
- in_data  input  Size  unsigned word to load
- desc  input  1  sort order, sampled on the first accepted word of a batch (0 ascending, 1 descending)
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts out_data
- out_data  output  Size  current sorted word
- busy  output  1  high in SORT and DRAIN

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD; wr_idx, pass, j and rd_idx are 0; desc_q=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
  - Storage contents are don't-care.
  - Reset in any state aborts the batch: partial loads, in-progress sorts and undelivered words are discarded.
- States: LOAD -> SORT -> DRAIN -> LOAD. There are no other states. Unused encodings return to LOAD.
- LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - Accept occurs when in_valid&in_ready. The word is written to mem[wr_idx] and wr_idx increments.
  - desc_q<=desc on the accept with wr_idx=0.
  - On the accept with wr_idx=Depth-1: wr_idx<=0, pass<=0, j<=0, next state SORT.
- SORT:
  - in_ready=0, busy=1. in_valid is ignored and no word is lost, because the producer holds its word.
  - Each cycle compares a=mem[j], b=mem[j+1] as unsigned values.
  - Swap condition: g when desc_q=0; l when desc_q=1. Equal words never swap, so the sort is stable.
  - j steps 0..Depth-2. When j=Depth-2: j<=0 and pass increments.
  - Exit when pass=Depth-2 and j=Depth-2: next state DRAIN, rd_idx<=0.
  - SORT lasts exactly (Depth-1)^2 cycles regardless of data; there is no early exit. Depth=4 gives 9 cycles.
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx] (registered storage, no combinational path from inputs), busy=1, in_ready=0.
  - Transfer occurs when out_valid&out_ready, then rd_idx increments.
  - out_data and out_valid stay stable while out_ready=0.
  - On the transfer with rd_idx=Depth-1: next state LOAD, rd_idx<=0.
- Latency:
  - Last input accepted at edge t; first out_valid=1 in the cycle after edge t+(Depth-1)^2.
  - in_ready returns to 1 in the cycle after the final output transfer. There is no same-cycle overlap of output and load.
- Widths:
  - wr_idx, rd_idx, j and pass are $clog2(Depth) bits.
  - No arithmetic on data; data is only compared and moved.

Decomposition:
- Shared package:
  - state encoding localparams (LOAD, SORT, DRAIN)
  - IDX_W=$clog2(Depth) helper
  - sort-order constants ASC=0, DESC=1
- One sub-module, cmp_swap:
  - Instantiates juntarComparadores #(Size) on (a,b) and muxes g/l by desc_q into a single swap bit.
  - Purely combinational.
- The top module holds the FSM, counters and storage, and performs the swap write-back of both mem[j] and mem[j+1] in the same cycle.

Test Plan:
- Ascending sort, Size=8, Depth=4, desc=0: load 0x35,0x07,0xFF,0x80 back-to-back.
  - Expect in_ready=0 for exactly 9 cycles, then out 0x07,0x35,0x80,0xFF with out_ready=1.
  - Expect busy to drop and in_ready=1 the cycle after the last transfer.
- Descending sort with duplicates and extremes: desc=1, load 0x05,0x00,0x05,0xFF.
  - Expect out 0xFF,0x05,0x05,0x00.
  - Rerun with desc=0 and input 0x05,0x05,0x03,0x05; expect 0x03,0x05,0x05,0x05.
- Backpressure: during DRAIN hold out_ready=0 for 3 cycles before the second word.
  - Expect out_valid=1 and out_data stable (second-smallest value) for all 3 cycles, and no word skipped or repeated.
- Input stall and gaps:
  - Insert idle cycles (in_valid=0) between load words; expect correct ordering.
  - Hold in_valid=1 with a new word during SORT; expect in_ready=0 and that word accepted as the first of the next batch only after DRAIN completes.
- Reset mid-operation: assert rst_n=0 for one cycle at SORT cycle 5.
  - Expect next cycle state LOAD, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Then a fresh batch 0x04,0x03,0x02,0x01 (asc) must output 0x01..0x04.
- Already-sorted and reverse-sorted inputs (0x01..0x04 and 0x04..0x01, asc):
  - Both must take exactly 9 SORT cycles and output 0x01,0x02,0x03,0x04.
